// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM states,
// register-index width and the per-buffer write/flush control bundle.
package pipeline_hazard_ctrl_pkg;

  localparam int HZ_REG_W = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_write;
  } hz_ctrl_t;

  function automatic hz_ctrl_t hz_ctrl(
    input logic pc_w,
    input logic ifid_w,
    input logic ifid_f,
    input logic idex_w,
    input logic idex_f,
    input logic exmem_w,
    input logic memwb_w
  );
    hz_ctrl_t c;
    c.pc_write    = pc_w;
    c.ifid_write  = ifid_w;
    c.ifid_flush  = ifid_f;
    c.idex_write  = idex_w;
    c.idex_flush  = idex_f;
    c.exmem_write = exmem_w;
    c.memwb_write = memwb_w;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse_cmp.sv
// Load-use detector: the ID instruction reads the register a load in EX
// is about to write. Register x0 is hardwired to zero and never matches.
module hazard_loaduse_cmp
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = HZ_REG_W
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  assign rs1_hit = use_rs1 & (rs1 == ex_rd);
  assign rs2_hit = use_rs2 & (rs2 == ex_rd);
  assign rd_live = (ex_rd != '0);
  assign hazard  = ex_mem_read & rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze,
// taken-branch squash, load-use bubble and a sticky memory-wait watchdog.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/load-use counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W   = HZ_REG_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_readReg1,
  input  logic [REG_W-1:0] id_readReg2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_writeReg,
  input  logic             ex_branchTaken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexWrite,
  output logic             idexFlush,
  output logic             exmemWrite,
  output logic             memwbWrite,
  output logic             memTimeout,
  output logic             waitState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount,
  output logic [CNT_W-1:0] loadUseCount
`endif
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO_CNT = WC_W'(TIMEOUT);

  hz_state_t       state;
  hz_state_t       state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_cnt_nxt;
  logic            timeout_q;
  logic            freeze;
  logic            load_use;
  hz_ctrl_t        ctrl;

  assign freeze = mem_req & ~mem_ready;

  hazard_loaduse_cmp #(
    .REG_W(REG_W)
  ) u_loaduse_cmp (
    .rs1        (id_readReg1),
    .rs2        (id_readReg2),
    .use_rs1    (id_useRs1),
    .use_rs2    (id_useRs2),
    .ex_mem_read(ex_memRead),
    .ex_rd      (ex_writeReg),
    .hazard     (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if ((state == MEM_WAIT) && (wait_cnt == TMO_CNT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // The watchdog only observes; the freeze itself is never broken by it.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt != TMO_CNT) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline inputs are held by the freeze itself, so a pending branch or
  // load-use simply reappears on the release cycle without extra storage.
  always_comb begin
    ctrl = hz_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    if (freeze) begin
      ctrl = '0;
    end else if (ex_branchTaken) begin
      ctrl = hz_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    end else if (load_use) begin
      ctrl = hz_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    if (!rst) begin
      ctrl = '0;
    end
  end

  assign pcWrite    = ctrl.pc_write;
  assign ifidWrite  = ctrl.ifid_write;
  assign ifidFlush  = ctrl.ifid_flush;
  assign idexWrite  = ctrl.idex_write;
  assign idexFlush  = ctrl.idex_flush;
  assign exmemWrite = ctrl.exmem_write;
  assign memwbWrite = ctrl.memwb_write;
  assign memTimeout = timeout_q;
  assign waitState  = rst & (state == MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic flush_cyc;
  logic lu_cyc;

  assign flush_cyc = ~freeze & ex_branchTaken;
  assign lu_cyc    = ~freeze & ~ex_branchTaken & load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles  <= '0;
      flushCount   <= '0;
      loadUseCount <= '0;
    end else begin
      if (freeze) begin
        stallCycles <= stallCycles + 1'b1;
      end
      if (flush_cyc) begin
        flushCount <= flushCount + 1'b1;
      end
      if (lu_cyc) begin
        loadUseCount <= loadUseCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4): directed hazard
// scenarios plus randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [REG_W-1:0] id_readReg1;
  logic [REG_W-1:0] id_readReg2;
  logic             id_useRs1;
  logic             id_useRs2;
  logic             ex_memRead;
  logic [REG_W-1:0] ex_writeReg;
  logic             ex_branchTaken;
  logic             mem_req;
  logic             mem_ready;
  logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush;
  logic exmemWrite, memwbWrite, memTimeout, waitState;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCycles, flushCount, loadUseCount;
`endif

  logic [7:0] got_v;
  assign got_v = {waitState, pcWrite, ifidWrite, ifidFlush, idexWrite,
                  idexFlush, exmemWrite, memwbWrite};

  pipeline_hazard_ctrl #(
    .REG_W  (REG_W),
    .TIMEOUT(TMO),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_readReg1   (id_readReg1),
    .id_readReg2   (id_readReg2),
    .id_useRs1     (id_useRs1),
    .id_useRs2     (id_useRs2),
    .ex_memRead    (ex_memRead),
    .ex_writeReg   (ex_writeReg),
    .ex_branchTaken(ex_branchTaken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pcWrite       (pcWrite),
    .ifidWrite     (ifidWrite),
    .ifidFlush     (ifidFlush),
    .idexWrite     (idexWrite),
    .idexFlush     (idexFlush),
    .exmemWrite    (exmemWrite),
    .memwbWrite    (memwbWrite),
    .memTimeout    (memTimeout),
    .waitState     (waitState)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCycles   (stallCycles),
    .flushCount    (flushCount),
    .loadUseCount  (loadUseCount)
`endif
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  // reference model: wait state = "previous cycle was frozen",
  // m_streak = number of consecutive frozen cycles so far
  bit m_in_wait;
  int m_streak;
  bit m_tmo;
  int m_stall, m_flush, m_lu;

  function automatic bit model_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit model_loaduse();
    bit hit1, hit2;
    hit1 = id_useRs1 && (id_readReg1 == ex_writeReg);
    hit2 = id_useRs2 && (id_readReg2 == ex_writeReg);
    return ex_memRead && (ex_writeReg != 0) && (hit1 || hit2);
  endfunction

  function automatic logic [7:0] model_out();
    logic [6:0] c;
    if (model_freeze())       c = 7'b0000000;
    else if (ex_branchTaken)  c = 7'b1111111;
    else if (model_loaduse()) c = 7'b0001111;
    else                      c = 7'b1101011;
    return {m_in_wait, c};
  endfunction

  task automatic model_reset();
    m_in_wait = 0; m_streak = 0; m_tmo = 0;
    m_stall = 0; m_flush = 0; m_lu = 0;
  endtask

  // advance the model across the coming rising edge (rst high)
  task automatic model_edge();
    if (m_in_wait && m_streak >= TMO) m_tmo = 1;
    if (model_freeze()) begin
      m_streak++;
      m_in_wait = 1;
      m_stall++;
    end else begin
      m_streak = 0;
      m_in_wait = 0;
      if (ex_branchTaken) m_flush++;
      else if (model_loaduse()) m_lu++;
    end
  endtask

  // drivers
  task automatic drive_idle();
    id_readReg1 = '0; id_readReg2 = '0; id_useRs1 = 0; id_useRs2 = 0;
    ex_memRead = 0; ex_writeReg = '0; ex_branchTaken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic drive_random();
    id_readReg1    = REG_W'($urandom_range(0, 3));
    id_readReg2    = REG_W'($urandom_range(0, 3));
    ex_writeReg    = REG_W'($urandom_range(0, 3));
    id_useRs1      = 1'($urandom_range(0, 1));
    id_useRs2      = 1'($urandom_range(0, 1));
    ex_memRead     = 1'($urandom_range(0, 1));
    ex_branchTaken = ($urandom_range(0, 99) < 15);
    mem_req        = ($urandom_range(0, 99) < 30);
    mem_ready      = ($urandom_range(0, 99) < 60);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive_random();
      @(negedge clk);
      n_checks++;
      if (got_v !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected %b", c, got_v, 8'h00);
      end
      n_checks++;
      if (memTimeout !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_timeout[%0d]: got %b expected 0", c, memTimeout);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if ((stallCycles | flushCount | loadUseCount) !== '0) begin
        n_errors++;
        $display("FAIL reset_counters[%0d]: got %0d/%0d/%0d expected 0", c,
                 stallCycles, flushCount, loadUseCount);
      end
`endif
    end
    model_reset();
    drive_idle();
    #2 rst = 1'b1;
  endtask

  task automatic test_load_use();
    logic [7:0] exp;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive_idle();
      ex_memRead = (c == 0); ex_writeReg = 5'd5;
      id_readReg1 = 5'd5; id_useRs1 = 1;
      exp = (c == 0) ? 8'b0_0001111 : 8'b0_1101011;
      @(negedge clk);
      n_checks++;
      if (got_v !== exp) begin
        n_errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", c, got_v, exp);
      end
      model_edge();
    end
  endtask

  task automatic test_x0();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive_idle();
      ex_memRead = 1;
      if (c == 0) begin
        ex_writeReg = 5'd0; id_readReg1 = 5'd0; id_useRs1 = 1;
      end else begin
        ex_writeReg = 5'd7; id_readReg2 = 5'd7; id_useRs2 = 0;
        id_readReg1 = 5'd3; id_useRs1 = 1;
      end
      @(negedge clk);
      n_checks++;
      if (got_v !== 8'b0_1101011) begin
        n_errors++;
        $display("FAIL no_stall[%0d]: got %b expected %b", c, got_v, 8'b0_1101011);
      end
      model_edge();
    end
  endtask

  task automatic test_branch_loaduse();
    @(posedge clk); #1;
    drive_idle();
    ex_memRead = 1; ex_writeReg = 5'd9; id_readReg2 = 5'd9; id_useRs2 = 1;
    ex_branchTaken = 1;
    @(negedge clk);
    n_checks++;
    if (got_v !== 8'b0_1111111) begin
      n_errors++;
      $display("FAIL branch_loaduse: got %b expected %b", got_v, 8'b0_1111111);
    end
    model_edge();
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp;
    int stall_base;
    stall_base = m_stall;
    exp_q.push_back(8'b0_0000000);
    exp_q.push_back(8'b1_0000000);
    exp_q.push_back(8'b1_0000000);
    exp_q.push_back(8'b1_1101011);
    exp_q.push_back(8'b0_1101011);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      drive_idle();
      mem_req = (c < 4); mem_ready = (c == 3);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp) begin
        n_errors++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", c, got_v, exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (c == 3) begin
        n_checks++;
        if (stallCycles !== CNT_W'(stall_base + 3)) begin
          n_errors++;
          $display("FAIL stall_cycles: got %0d expected %0d", stallCycles, stall_base + 3);
        end
      end
`endif
      model_edge();
    end
    if (stall_base < 0) $display("note: stall base %0d", stall_base);
  endtask

  task automatic test_branch_wait();
    logic [7:0] exp;
    exp_q.push_back(8'b0_0000000);
    exp_q.push_back(8'b1_0000000);
    exp_q.push_back(8'b1_1111111);
    exp_q.push_back(8'b0_1101011);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive_idle();
      ex_branchTaken = (c < 3);
      mem_req = (c < 3); mem_ready = (c == 2);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp) begin
        n_errors++;
        $display("FAIL branch_wait[%0d]: got %b expected %b", c, got_v, exp);
      end
      model_edge();
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      drive_random();
      @(negedge clk);
      exp = model_out();
      n_checks++;
      if (got_v !== exp) begin
        n_errors++;
        $display("FAIL random_ctrl[%0d]: got %b expected %b", c, got_v, exp);
      end
      n_checks++;
      if (memTimeout !== m_tmo) begin
        n_errors++;
        $display("FAIL random_timeout[%0d]: got %b expected %b", c, memTimeout, m_tmo);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (stallCycles !== CNT_W'(m_stall) || flushCount !== CNT_W'(m_flush) ||
          loadUseCount !== CNT_W'(m_lu)) begin
        n_errors++;
        $display("FAIL random_counters[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", c,
                 stallCycles, flushCount, loadUseCount, m_stall, m_flush, m_lu);
      end
`endif
      model_edge();
    end
  endtask

  task automatic test_timeout_reset();
    logic [7:0] exp;
    // asynchronous pulse between edges clears anything left from earlier traffic
    @(posedge clk); #3;
    rst = 1'b0;
    drive_idle();
    #1;
    model_reset();
    n_checks++;
    if (memTimeout !== 1'b0 || got_v !== 8'h00) begin
      n_errors++;
      $display("FAIL pre_reset: got tmo=%b ctrl=%b expected 0/00000000", memTimeout, got_v);
    end
    @(negedge clk); #2;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive_idle();
      mem_req = 1; mem_ready = 0;
      @(negedge clk);
      exp = {(c > 0) ? 1'b1 : 1'b0, 7'b0000000};
      n_checks++;
      if (got_v !== exp) begin
        n_errors++;
        $display("FAIL timeout_freeze[%0d]: got %b expected %b", c, got_v, exp);
      end
      n_checks++;
      if (memTimeout !== (c >= 5) || memTimeout !== m_tmo) begin
        n_errors++;
        $display("FAIL timeout_flag[%0d]: got %b expected %b", c, memTimeout, (c >= 5));
      end
      model_edge();
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (got_v !== 8'h00 || memTimeout !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got tmo=%b ctrl=%b expected 0/00000000", memTimeout, got_v);
    end
    @(negedge clk);
    n_checks++;
    if (got_v !== 8'h00) begin
      n_errors++;
      $display("FAIL held_reset: got %b expected %b", got_v, 8'h00);
    end
    #2;
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (got_v !== 8'b0_1101011 || memTimeout !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset: got tmo=%b ctrl=%b expected 0/01101011", memTimeout, got_v);
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_x0();
    test_branch_loaduse();
    test_mem_wait();
    test_branch_wait();
    test_random();
    test_timeout_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Handles load-use hazards (bubble into ID/EX), taken-branch squash (IF/ID + ID/EX) and data-memory wait (full freeze), with a wait-timeout watchdog.

Parameters:
- REG_W, 5, register index width.
- TIMEOUT, 255, memory-wait cycles before memTimeout is raised (>=1).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_readReg1  in  REG_W  rs1 index of the instruction in ID
- id_readReg2  in  REG_W  rs2 index of the instruction in ID
- id_useRs1  in  1  ID instruction reads rs1
- id_useRs2  in  1  ID instruction reads rs2
- ex_memRead  in  1  ID/EX buffer memRead_actual
- ex_writeReg  in  REG_W  ID/EX buffer writeReg_actual
- ex_branchTaken  in  1  branch/jump resolved taken in EX
- mem_req  in  1  MEM stage accessing data memory (read or write)
- mem_ready  in  1  data memory completes the access this cycle
- pcWrite  out  1  PC register enable
- ifidWrite  out  1  IF/ID buffer enable
- ifidFlush  out  1  IF/ID clear to NOP
- idexWrite  out  1  ID/EX buffer enable
- idexFlush  out  1  ID/EX control bits cleared (bubble)
- exmemWrite  out  1  EX/MEM buffer enable
- memwbWrite  out  1  MEM/WB buffer enable
- memTimeout  out  1  sticky watchdog error
- waitState  out  1  1 while FSM is in MEM_WAIT

Behaviour:
- Reset (rst=0, async): state=RUN, wait_cnt=0, memTimeout=0.
- While rst=0, all outputs are forced: all *Write=0, all *Flush=0, waitState=0.
- FSM states: RUN and MEM_WAIT. waitState=(state==MEM_WAIT).
- Control outputs are combinational (Mealy) from state and inputs, with zero latency. Priority, highest first:
- 1. freeze = mem_req & ~mem_ready, in either state.
  - All *Write=0 and all *Flush=0.
  - An EX-stage branch or load-use condition is held and applied on the release cycle.
- 2. Taken branch (ex_branchTaken, no freeze):
  - pcWrite=1, ifidWrite=1, ifidFlush=1, idexWrite=1, idexFlush=1, exmemWrite=1, memwbWrite=1.
  - A simultaneous load-use match is ignored, because the ID instruction is squashed.
- 3. Load-use, no freeze and no branch. Condition: ex_memRead & ex_writeReg!=0 & ((id_useRs1 & id_readReg1==ex_writeReg) | (id_useRs2 & id_readReg2==ex_writeReg)).
  - pcWrite=0, ifidWrite=0, idexWrite=1, idexFlush=1, exmemWrite=1, memwbWrite=1.
  - Exactly one bubble; the next cycle the load is in MEM and the condition clears.
- 4. Otherwise: all *Write=1, all *Flush=0.
- Register x0 never causes a stall.
- Transitions:
  - RUN->MEM_WAIT when freeze; wait_cnt<=1.
  - MEM_WAIT stays while freeze; wait_cnt increments and saturates at TIMEOUT.
  - MEM_WAIT->RUN when mem_ready=1 or mem_req=0; wait_cnt<=0.
  - The release cycle applies rules 2-4.
  - A zero-wait access (mem_req & mem_ready in RUN) stays in RUN.
- Watchdog: memTimeout<=1 when wait_cnt==TIMEOUT while in MEM_WAIT. It is sticky until reset. The freeze continues regardless.
- Mid-operation reset (e.g. during MEM_WAIT): immediate return to RUN; the counter and the flag clear.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stallCycles, flushCount and loadUseCount, each CNT_W wide, wrapping, reset to 0.
  - stallCycles increments on every freeze cycle.
  - flushCount increments on every rule-2 cycle.
  - loadUseCount increments on every rule-3 cycle.
- Undefined: these ports and registers do not exist; control behaviour is identical.

Decomposition:
- Shared pipeline package:
  - hz_state_t enum {RUN, MEM_WAIT}
  - REG_W constant
  - typedef of the stage-control bundle: write and flush bits per buffer.
- One natural sub-module: hazard_loaduse_cmp, a combinational rs1/rs2-vs-rd match with x0 exclusion. The FSM and counters stay in the top module.

Test Plan:
- Load-use: ex_memRead=1, ex_writeReg=5, id_readReg1=5, id_useRs1=1 -> one cycle pcWrite=0, ifidWrite=0, idexFlush=1; next cycle all Write=1.
- x0 case: ex_writeReg=0, id_readReg1=0, id_useRs1=1, ex_memRead=1 -> no stall. Also id_useRs2=0 with an rs2 match -> no stall.
- Branch plus load-use in the same cycle -> ifidFlush=1, idexFlush=1, pcWrite=1, no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> 3 cycles with all Write=0 and waitState=1; the release cycle has all Write=1, then state RUN. With the feature enabled, stallCycles=3.
- Branch during wait: ex_branchTaken=1 held during a 2-cycle wait -> no flush while frozen; flush on the release cycle.
- Timeout and reset: TIMEOUT=4, mem_ready held 0 -> memTimeout=1 after 4 wait cycles and stays 1. Then pulse rst=0 asynchronously mid-wait -> waitState=0, memTimeout=0, all Write=0 during reset.
